// File: rtl/mem_io_port.sv
// Single-outstanding load/store port: steers an accepted request to the data RAM
// or to the memory-mapped LED/switch registers and reports completion with done_o.
module mem_io_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [21:0] addr_high_i,
    input  logic [31:0] wdata_i,
    output logic [13:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic [23:0] switch_i,
    output logic [23:0] led_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MEM_RD   = 3'd1;
    localparam logic [2:0] S_MEM_WAIT = 3'd2;
    localparam logic [2:0] S_MEM_WR   = 3'd3;
    localparam logic [2:0] S_IO       = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [7:0] OFS_LED = 8'h60;
    localparam logic [7:0] OFS_SW  = 8'h70;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } req_t;

    req_t       req_q;
    logic [2:0] state;

    // Only the word index and IO offset bits are needed after acceptance.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:16];

    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);
    assign dmem_we_o    = (state == S_MEM_WR);
    assign dmem_addr_o  = req_q.addr[15:2];
    assign dmem_wdata_o = req_q.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            req_q   <= '0;
            rdata_o <= '0;
            err_o   <= 1'b0;
            led_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        req_q <= '{addr: addr_i[15:0], wdata: wdata_i,
                                   rd: mem_read_i, wr: mem_write_i};
                        err_o <= 1'b0;
                        // Malformed and empty requests complete without touching anything.
                        if (mem_read_i && mem_write_i) begin
                            state   <= S_DONE;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else if (!mem_read_i && !mem_write_i) begin
                            state   <= S_DONE;
                            rdata_o <= '0;
                        end else if (addr_high_i == 22'h3FFFFF) begin
                            state <= S_IO;
                        end else if (addr_i[1:0] != 2'b00) begin
                            state   <= S_DONE;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else if (mem_read_i) begin
                            state <= S_MEM_RD;
                        end else begin
                            state <= S_MEM_WR;
                        end
                    end
                end
                S_MEM_RD: state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    rdata_o <= dmem_rdata_i;
                    state   <= S_DONE;
                end
                S_MEM_WR: begin
                    rdata_o <= '0;
                    state   <= S_DONE;
                end
                S_IO: begin
                    rdata_o <= '0;
                    state   <= S_DONE;
                    case (req_q.addr[7:0])
                        OFS_LED: begin
                            if (req_q.wr) led_o   <= req_q.wdata[23:0];
                            if (req_q.rd) rdata_o <= {8'h00, led_o};
                        end
                        OFS_SW: begin
                            if (req_q.rd) rdata_o <= {8'h00, switch_i};
                        end
                        default: err_o <= 1'b1;
                    endcase
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_port.sv
// Directed plus randomized bench for mem_io_port against a transaction-level model
// with its own memory image, LED shadow and expected completion latency.
module tb_mem_io_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, mem_read_i, mem_write_i;
    logic [31:0] addr_i, wdata_i;
    logic [21:0] addr_high_i;
    logic [13:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [31:0] dmem_wdata_o, dmem_rdata_i;
    logic [23:0] switch_i, led_o;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;

    int n_chk = 0;
    int n_err = 0;

    mem_io_port dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .addr_i(addr_i), .addr_high_i(addr_high_i),
        .wdata_i(wdata_i), .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .switch_i(switch_i), .led_o(led_o), .busy_o(busy_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM stand-in, one-cycle read latency.
    logic        ram_clr;
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
        end else if (dmem_we_o) begin
            ram[dmem_addr_o[5:0]] <= dmem_wdata_o;
        end
        dmem_rdata_i <= ram[dmem_addr_o[5:0]];
    end

    int          we_cnt;
    logic [13:0] we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        if (dmem_we_o) begin
            we_cnt  = we_cnt + 1;
            we_addr = dmem_addr_o;
            we_data = dmem_wdata_o;
        end
    end

    // Reference state: memory image and LED register as seen by software.
    logic [31:0] ref_mem [0:63];
    logic [23:0] ref_led;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        addr_i = addr; addr_high_i = addr[31:10]; wdata_i = wd;
    endtask

    task automatic scramble();
        req_i = 1'b0; mem_read_i = $urandom_range(0, 1); mem_write_i = $urandom_range(0, 1);
        addr_i = $urandom(); addr_high_i = 22'h3FFFFF; wdata_i = $urandom();
    endtask

    // One complete transaction: predict, drive, wait for done with a bound, compare.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [23:0] sw);
        int          exp_lat, lat;
        logic        exp_err, is_store, seen;
        logic [31:0] exp_rd;
        int          exp_we;
        exp_err = 1'b0; exp_rd = 32'h0; exp_we = 0; is_store = 1'b0;
        if (rd && wr) begin
            exp_lat = 1; exp_err = 1'b1;
        end else if (!rd && !wr) begin
            exp_lat = 1;
        end else if (addr[31:10] == 22'h3FFFFF) begin
            exp_lat = 2;
            if (addr[7:0] == 8'h60) begin
                if (wr) begin ref_led = wd[23:0]; is_store = 1'b1; end
                else exp_rd = {8'h0, ref_led};
            end else if (addr[7:0] == 8'h70) begin
                if (rd) exp_rd = {8'h0, sw}; else is_store = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end else if (addr[1:0] != 2'b00) begin
            exp_lat = 1; exp_err = 1'b1;
        end else if (rd) begin
            exp_lat = 3; exp_rd = ref_mem[addr[7:2]];
        end else begin
            exp_lat = 2; exp_we = 1; is_store = 1'b1; ref_mem[addr[7:2]] = wd;
        end

        @(negedge clk);
        we_cnt = 0;
        switch_i = sw;
        drive(rd, wr, addr, wd);
        @(posedge clk);
        #1 scramble();
        lat = 1; seen = 1'b0;
        @(negedge clk);
        chk({tag, ".busy"}, {31'h0, busy_o}, 32'h1);
        while (!seen && lat <= 8) begin
            if (done_o) seen = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        chk({tag, ".lat"}, seen ? lat : 32'hFFFF_FFFF, exp_lat);
        chk({tag, ".err"}, {31'h0, err_o}, {31'h0, exp_err});
        if (!is_store) chk({tag, ".rdata"}, rdata_o, exp_rd);
        chk({tag, ".led"}, {8'h0, led_o}, {8'h0, ref_led});
        chk({tag, ".we_cnt"}, we_cnt, exp_we);
        if (exp_we == 1) begin
            chk({tag, ".we_addr"}, {18'h0, we_addr}, {18'h0, addr[15:2]});
            chk({tag, ".we_data"}, we_data, wd);
        end
        @(negedge clk);
        chk({tag, ".idle"}, {31'h0, busy_o}, 32'h0);
    endtask

    initial begin
        int          done_cnt;
        int          done_at[$];
        logic [31:0] r, a;
        logic [23:0] sw;
        rst = 1'b1; ram_clr = 1'b1; ref_led = 24'h0;
        req_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        addr_i = '0; addr_high_i = '0; wdata_i = '0; switch_i = '0; we_cnt = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        #3;
        chk("rst.busy", {31'h0, busy_o}, 32'h0);
        chk("rst.done", {31'h0, done_o}, 32'h0);
        chk("rst.err", {31'h0, err_o}, 32'h0);
        chk("rst.we", {31'h0, dmem_we_o}, 32'h0);
        chk("rst.rdata", rdata_o, 32'h0);
        chk("rst.led", {8'h0, led_o}, 32'h0);
        chk("rst.daddr", {18'h0, dmem_addr_o}, 32'h0);
        chk("rst.dwdata", dmem_wdata_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; ram_clr = 1'b0;

        access("st10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 24'h0);
        access("ld10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 24'h0);
        access("io_led_st", 1'b0, 1'b1, 32'hFFFF_FC60, 32'h00A5A5A5, 24'h0);
        access("io_sw_ld", 1'b1, 1'b0, 32'hFFFF_FC70, 32'h0, 24'h123456);
        access("io_led_ld", 1'b1, 1'b0, 32'hFFFF_FC60, 32'h0, 24'h0);
        access("ld_mis", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 24'h0);
        access("ld10b", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 24'h0);
        access("io_bad", 1'b1, 1'b0, 32'hFFFF_FC64, 32'h0, 24'h0);
        access("st_mis", 1'b0, 1'b1, 32'h0000_0012, 32'h12345678, 24'h0);
        access("rdwr", 1'b1, 1'b1, 32'h0000_0010, 32'h0BADF00D, 24'h0);
        access("noop", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 24'h0);
        access("io_sw_st", 1'b0, 1'b1, 32'hFFFF_FC70, 32'h00FFFFFF, 24'h0);
        access("st20", 1'b0, 1'b1, 32'h0000_0020, 32'h5555AAAA, 24'h0);

        // Request pulsed while a load is in MEM_WAIT must not start a second access.
        @(negedge clk); drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(posedge clk); #1 req_i = 1'b0;
        @(posedge clk); #1 req_i = 1'b1;
        @(posedge clk); #1 req_i = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        chk("pulse.done_cnt", done_cnt, 1);
        chk("pulse.idle", {31'h0, busy_o}, 32'h0);

        // Request held high: back-to-back loads, one IDLE cycle between them.
        @(negedge clk); drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_o) begin
                done_at.push_back(i);
                chk("held.rdata", rdata_o, ref_mem[4]);
            end
        end
        req_i = 1'b0;
        chk("held.count", done_at.size(), 4);
        if (done_at.size() >= 2) begin
            chk("held.first", done_at[0], 2);
            chk("held.period", done_at[1] - done_at[0], 4);
        end
        repeat (6) @(negedge clk);
        chk("held.idle", {31'h0, busy_o}, 32'h0);

        // Reset in the MEM_WR cycle aborts the store.
        @(negedge clk); drive(1'b0, 1'b1, 32'h0000_0020, 32'h11112222);
        @(posedge clk); #1 scramble();
        @(negedge clk); #1;
        chk("abort.we_pre", {31'h0, dmem_we_o}, 32'h1);
        rst = 1'b1; ref_led = 24'h0;
        #1;
        chk("abort.we", {31'h0, dmem_we_o}, 32'h0);
        chk("abort.busy", {31'h0, busy_o}, 32'h0);
        chk("abort.led", {8'h0, led_o}, 32'h0);
        done_cnt = 0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        chk("abort.no_done", done_cnt, 0);
        access("ld20_after", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 24'h0);

        // Reset in the IO cycle of an LED store leaves the LEDs cleared.
        @(negedge clk); drive(1'b0, 1'b1, 32'hFFFF_FC60, 32'h00C3C3C3);
        @(posedge clk); #1 scramble();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_io.led", {8'h0, led_o}, 32'h0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            sw = r[23:0];
            a = {1'b0, r[30:16], 9'h0, 5'($urandom_range(0, 31)), 2'b00};
            case ($urandom_range(0, 9))
                0, 1, 2: access("rnd_st", 1'b0, 1'b1, a, $urandom(), sw);
                3, 4, 5: access("rnd_ld", 1'b1, 1'b0, a, $urandom(), sw);
                6: begin
                    case ($urandom_range(0, 2))
                        0: a = {22'h3FFFFF, r[1:0], 8'h60};
                        1: a = {22'h3FFFFF, r[1:0], 8'h70};
                        default: a = {22'h3FFFFF, r[1:0], r[15:8]};
                    endcase
                    access("rnd_io", r[31], !r[31], a, $urandom(), sw);
                end
                7: access("rnd_mis", r[31], !r[31], a | 32'($urandom_range(1, 3)), $urandom(), sw);
                8: access("rnd_rdwr", 1'b1, 1'b1, a, $urandom(), sw);
                default: access("rnd_noop", 1'b0, 1'b0, a, $urandom(), sw);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
